// File: rtl/keystream_buffer_if.sv
// rtl/keystream_buffer_if.sv - hash core, keystream consumer and control signals of keystream_buffer
interface keystream_buffer_if #(
    parameter int BYTE_W = 8,
    parameter int HASH_W = 64
);
    localparam int N_BYTES = HASH_W / BYTE_W;
    localparam int CNT_W   = $clog2(N_BYTES + 1);

    logic              hash_req_o;
    logic              hash_valid_i;
    logic [HASH_W-1:0] hash_data_i;
    logic              ks_req_i;
    logic              ks_ready_o;
    logic              ks_valid_o;
    logic [BYTE_W-1:0] ks_byte_o;
    logic              flush_i;
    logic [CNT_W-1:0]  remaining_o;
    logic [1:0]        state_o;

    // master: the keystream buffer itself; slave: hash core, consumer and control
    modport master (
        output hash_req_o, ks_ready_o, ks_valid_o, ks_byte_o, remaining_o, state_o,
        input  hash_valid_i, hash_data_i, ks_req_i, flush_i
    );
    modport slave (
        input  hash_req_o, ks_ready_o, ks_valid_o, ks_byte_o, remaining_o, state_o,
        output hash_valid_i, hash_data_i, ks_req_i, flush_i
    );
endinterface

// File: rtl/keystream_buffer.sv
// rtl/keystream_buffer.sv - hash word to keystream symbol buffer; KS_PREFETCH_EN adds a shadow word for zero-bubble refills
module keystream_buffer #(
    parameter int BYTE_W = 8,
    parameter int HASH_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    keystream_buffer_if.master bus
);
    localparam int N_BYTES = HASH_W / BYTE_W;
    localparam int CNT_W   = $clog2(N_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_BYTES);

    generate
        if ((HASH_W % BYTE_W) != 0 || N_BYTES < 2) begin : g_bad_params
            $error("keystream_buffer: HASH_W must be a multiple of BYTE_W with at least two symbols");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_GROUND    = 2'd0,
        ST_FETCH     = 2'd1,
        ST_READY     = 2'd2,
        ST_EXHAUSTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [HASH_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  marker_q, marker_d;
    logic              outst_q, outst_d;
    logic              hash_req_q, hash_req_d;
    logic              ks_valid_q, ks_valid_d;
    logic [BYTE_W-1:0] ks_byte_q, ks_byte_d;
`ifdef KS_PREFETCH_EN
    logic [HASH_W-1:0] shd_q, shd_d;
    logic              shd_valid_q, shd_valid_d;
`endif

    logic accept;
    logic last_sym;

    assign accept   = (state_q == ST_READY) && bus.ks_req_i;
    assign last_sym = (marker_q == LAST_IDX);

    // Next-state logic: flush overrides everything; hash returns always retire the outstanding flag
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        marker_d   = marker_q;
        outst_d    = outst_q;
        hash_req_d = 1'b0;
        ks_valid_d = 1'b0;
        ks_byte_d  = ks_byte_q;
`ifdef KS_PREFETCH_EN
        shd_d       = shd_q;
        shd_valid_d = shd_valid_q;
`endif
        if (bus.hash_valid_i) begin
            outst_d = 1'b0;
        end
        if (bus.flush_i) begin
            state_d  = ST_GROUND;
            buf_d    = '0;
            marker_d = '0;
`ifdef KS_PREFETCH_EN
            shd_d       = '0;
            shd_valid_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_GROUND, ST_EXHAUSTED: begin
                    if (bus.ks_req_i && !outst_q) begin
                        hash_req_d = 1'b1;
                        outst_d    = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bus.hash_valid_i) begin
                        buf_d    = bus.hash_data_i;
                        marker_d = '0;
                        state_d  = ST_READY;
                    end
                end
                ST_READY: begin
                    if (accept) begin
                        ks_valid_d = 1'b1;
                        ks_byte_d  = buf_q[int'(marker_q)*BYTE_W +: BYTE_W];
                        marker_d   = marker_q + CNT_W'(1);
                    end
`ifdef KS_PREFETCH_EN
                    if (bus.hash_valid_i && !shd_valid_q) begin
                        shd_d       = bus.hash_data_i;
                        shd_valid_d = 1'b1;
                    end
                    if (accept && last_sym) begin
                        if (shd_valid_q) begin
                            buf_d       = shd_q;
                            marker_d    = '0;
                            shd_valid_d = 1'b0;
                        end else if (bus.hash_valid_i) begin
                            // the prefetched word lands exactly at the boundary: use it directly
                            buf_d       = bus.hash_data_i;
                            marker_d    = '0;
                            shd_valid_d = 1'b0;
                        end else if (outst_q) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_EXHAUSTED;
                        end
                    end else if (!shd_valid_q && !outst_q) begin
                        hash_req_d = 1'b1;
                        outst_d    = 1'b1;
                    end
`else
                    if (accept && last_sym) begin
                        state_d = ST_EXHAUSTED;
                    end
`endif
                end
                default: begin
                    state_d = ST_GROUND;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GROUND;
            buf_q      <= '0;
            marker_q   <= '0;
            outst_q    <= 1'b0;
            hash_req_q <= 1'b0;
            ks_valid_q <= 1'b0;
            ks_byte_q  <= '0;
`ifdef KS_PREFETCH_EN
            shd_q       <= '0;
            shd_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            marker_q   <= marker_d;
            outst_q    <= outst_d;
            hash_req_q <= hash_req_d;
            ks_valid_q <= ks_valid_d;
            ks_byte_q  <= ks_byte_d;
`ifdef KS_PREFETCH_EN
            shd_q       <= shd_d;
            shd_valid_q <= shd_valid_d;
`endif
        end
    end

    assign bus.hash_req_o  = hash_req_q;
    assign bus.ks_ready_o  = (state_q == ST_READY);
    assign bus.ks_valid_o  = ks_valid_q;
    assign bus.ks_byte_o   = ks_byte_q;
    assign bus.remaining_o = (state_q == ST_READY) ? (FULL_CNT - marker_q) : '0;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_keystream_buffer.sv
// tb/tb_keystream_buffer.sv - scoreboard bench for keystream_buffer
module tb_keystream_buffer;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   nvec  = 0;
    int   nfail = 0;

    typedef struct {
        logic [7:0] b;
        int         at;
    } exp_t;
    exp_t sb_q[$];

    keystream_buffer_if #(.BYTE_W(8), .HASH_W(64)) bus ();
    keystream_buffer #(.BYTE_W(8), .HASH_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        exp_t e;
        e.b  = b;
        e.at = cyc + 1;
        sb_q.push_back(e);
    endtask

    // Monitor: every ks_valid_o pulse must match the oldest expected symbol, in value and cycle
    exp_t got;
    always @(negedge clk) begin
        if (bus.ks_valid_o === 1'b1) begin
            nvec++;
            if (sb_q.size() == 0) begin
                nfail++;
                $display("FAIL ks_unexpected: got byte %02h at cycle %0d, required no output", bus.ks_byte_o, cyc);
            end else begin
                got = sb_q.pop_front();
                if (bus.ks_byte_o !== got.b || cyc != got.at) begin
                    nfail++;
                    $display("FAIL ks_byte: got %02h at cycle %0d, required %02h at cycle %0d",
                             bus.ks_byte_o, cyc, got.b, got.at);
                end
            end
        end
    end

    logic [63:0] pf_words [3];
    int          hreq;
    int          acc;
    int          widx;
    logic        prev;

    initial begin
        rst_n            = 1'b0;
        bus.hash_valid_i = 1'b0;
        bus.hash_data_i  = '0;
        bus.ks_req_i     = 1'b0;
        bus.flush_i      = 1'b0;
        step();
        step();
        chk("rst_state", bus.state_o, 0);
        chk("rst_ready", bus.ks_ready_o, 0);
        chk("rst_valid", bus.ks_valid_o, 0);
        chk("rst_hreq", bus.hash_req_o, 0);
        chk("rst_remaining", bus.remaining_o, 0);
        chk("rst_byte", bus.ks_byte_o, 0);
        rst_n = 1'b1;
        step();

        // reset asserted mid-FETCH with a hash arriving
        bus.ks_req_i = 1'b1;
        step();
        chk("a_hreq", bus.hash_req_o, 1);
        chk("a_state_fetch", bus.state_o, 1);
        bus.ks_req_i = 1'b0;
        step();
        rst_n            = 1'b0;
        bus.hash_valid_i = 1'b1;
        bus.hash_data_i  = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        chk("a_state_in_reset", bus.state_o, 0);
        bus.hash_valid_i = 1'b0;
        rst_n            = 1'b1;
        step();
        chk("a_state_after", bus.state_o, 0);
        chk("a_remaining_after", bus.remaining_o, 0);

`ifdef KS_PREFETCH_EN
        pf_words[0] = 64'h0807060504030201;
        pf_words[1] = 64'h100F0E0D0C0B0A09;
        pf_words[2] = 64'h1817161514131211;
        bus.ks_req_i = 1'b1;
        step();
        prev = 1'b0;
        widx = 0;
        hreq = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n <= 19 && bus.hash_req_o === 1'b1) hreq++;
            bus.hash_valid_i = prev;
            bus.hash_data_i  = (prev && widx < 3) ? pf_words[widx] : 64'h0;
            if (prev) widx++;
            prev = bus.hash_req_o;
            if (n >= 3 && n <= 18) begin
                chk("pf_ready", bus.ks_ready_o, 1);
                push(8'(n - 2));
            end
            if (n >= 4 && n <= 19) chk("pf_state", bus.state_o, 2);
            if (n == 19) bus.ks_req_i = 1'b0;
            step();
        end
        bus.hash_valid_i = 1'b0;
        chk("pf_hreq_count", hreq, 3);
`else
        // miss, eight back-to-back symbols, exhaustion and a single refill request
        bus.ks_req_i = 1'b1;
        step();
        chk("b_hreq", bus.hash_req_o, 1);
        chk("b_state_fetch", bus.state_o, 1);
        step();
        step();
        bus.hash_valid_i = 1'b1;
        bus.hash_data_i  = 64'h0807060504030201;
        step();
        bus.hash_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("b_remaining", bus.remaining_o, 8 - i);
            chk("b_state_ready", bus.state_o, 2);
            push(8'(i + 1));
            step();
        end
        chk("b_state_exh", bus.state_o, 3);
        chk("b_ready_exh", bus.ks_ready_o, 0);
        chk("b_remaining_exh", bus.remaining_o, 0);
        step();
        chk("b_refill_hreq", bus.hash_req_o, 1);
        chk("b_refill_state", bus.state_o, 1);
        hreq = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.hash_req_o === 1'b1) hreq++;
        end
        chk("b_extra_hreq", hreq, 0);

        // request toggled every other cycle
        bus.ks_req_i     = 1'b0;
        bus.hash_valid_i = 1'b1;
        bus.hash_data_i  = 64'h1817161514131211;
        step();
        bus.hash_valid_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            chk("c_remaining", bus.remaining_o, 8 - acc);
            if (k % 2 == 0) begin
                bus.ks_req_i = 1'b1;
                push(8'(8'h11 + acc));
                acc++;
            end else begin
                bus.ks_req_i = 1'b0;
            end
            step();
        end
        chk("c_remaining_end", bus.remaining_o, 2);
        for (int j = 0; j < 2; j++) begin
            bus.ks_req_i = 1'b1;
            push(8'(8'h17 + j));
            step();
        end
        chk("c_state_exh", bus.state_o, 3);
        step();
        chk("c_hreq", bus.hash_req_o, 1);

        // flush with a request outstanding; late word must be discarded
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("d_state_flush", bus.state_o, 0);
        chk("d_remaining_flush", bus.remaining_o, 0);
        step();
        chk("d_wait_hreq0", bus.hash_req_o, 0);
        step();
        chk("d_wait_hreq1", bus.hash_req_o, 0);
        bus.hash_valid_i = 1'b1;
        bus.hash_data_i  = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        bus.hash_valid_i = 1'b0;
        chk("d_late_state", bus.state_o, 0);
        chk("d_late_remaining", bus.remaining_o, 0);
        step();
        chk("d_new_hreq", bus.hash_req_o, 1);
        step();
        bus.hash_valid_i = 1'b1;
        bus.hash_data_i  = 64'h2827262524232221;
        step();
        bus.hash_valid_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            push(8'(8'h21 + j));
            step();
        end

        // flush after three symbols with an accept in the same cycle
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("e_state", bus.state_o, 0);
        chk("e_remaining", bus.remaining_o, 0);
        chk("e_ready", bus.ks_ready_o, 0);
        chk("e_valid", bus.ks_valid_o, 0);
        chk("e_byte_hold", bus.ks_byte_o, 8'h23);
        step();
        chk("e_hreq", bus.hash_req_o, 1);

        // flush and hash_valid_i in the same cycle
        bus.flush_i      = 1'b1;
        bus.hash_valid_i = 1'b1;
        bus.hash_data_i  = 64'h5555_5555_5555_5555;
        step();
        bus.flush_i      = 1'b0;
        bus.hash_valid_i = 1'b0;
        chk("f_state", bus.state_o, 0);
        chk("f_valid", bus.ks_valid_o, 0);
        chk("f_remaining", bus.remaining_o, 0);
        step();
        chk("f_hreq", bus.hash_req_o, 1);
        step();
        bus.hash_valid_i = 1'b1;
        bus.hash_data_i  = 64'h3837363534333231;
        step();
        bus.hash_valid_i = 1'b0;
        chk("f_state_ready", bus.state_o, 2);
        push(8'h31);
        step();
        bus.ks_req_i = 1'b0;
        step();
        chk("f_remaining_after", bus.remaining_o, 7);
`endif
        step();
        step();
        chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/keystream_buffer.md
Name: keystream_buffer

Overview:
- Parametrised successor to the stream-cipher hash generator.
- Holds one HASH_W-bit hash word and hands it out BYTE_W bits at a time, on demand, to the encryption block.
- On exhaustion, requests a new hash from the hash core with a one-cycle pulse.
- Adds flush support, remaining-count reporting and an optional zero-bubble prefetch buffer.

Parameters:
- BYTE_W, 8, width of one keystream symbol.
- HASH_W, 64, width of one hash word; must be a multiple of BYTE_W, giving N_BYTES = HASH_W/BYTE_W >= 2 (elaboration error otherwise).
- CNT_W, $clog2(N_BYTES+1), width of the remaining count (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- hash_req_o  out  1  one-cycle pulse requesting a new hash word.
- hash_valid_i  in  1  one-cycle strobe; hash_data_i is valid.
- hash_data_i  in  HASH_W  hash word from the hash core.
- ks_req_i  in  1  consumer requests a symbol; held until accepted.
- ks_ready_o  out  1  a request is accepted this cycle when ks_req_i & ks_ready_o.
- ks_valid_o  out  1  one-cycle strobe; ks_byte_o is valid.
- ks_byte_o  out  BYTE_W  keystream symbol.
- flush_i  in  1  synchronous discard of all buffered state.
- remaining_o  out  CNT_W  unconsumed symbols in the active buffer.
- state_o  out  2  GROUND=0, FETCH=1, READY=2, EXHAUSTED=3.

Behaviour:
- Reset (rst_n low, asynchronous): state GROUND, buffer 0, marker 0, outstanding flag 0.
  - All outputs 0.
- Byte order: symbol i = hash_data_i[i*BYTE_W +: BYTE_W]; LSB symbol first.
- Outstanding requests: at most one hash request outstanding at a time; the flag sets on hash_req_o and clears on hash_valid_i.
- GROUND / EXHAUSTED:
  - ks_ready_o=0.
  - If ks_req_i=1 and nothing is outstanding: hash_req_o=1 next cycle, then go to FETCH.
  - hash_valid_i in GROUND is discarded.
- FETCH:
  - ks_ready_o=0.
  - On hash_valid_i: capture the word, marker=0, go to READY next cycle.
- READY:
  - ks_ready_o=1.
  - Accept at cycle t: ks_byte_o=symbol[marker] and ks_valid_o=1 at t+1; marker increments.
  - Back-to-back accepts every cycle are allowed.
  - Accepting symbol N_BYTES-1 moves the state to EXHAUSTED.
  - Unsolicited hash_valid_i in READY is ignored (non-prefetch build).
- Miss latency: ks_req_i rises at t in GROUND -> hash_req_o at t+1 -> hash_valid_i at t+1+k -> READY at t+2+k -> first byte valid at t+3+k.
- remaining_o: N_BYTES-marker in READY; 0 in all other states.
- ks_valid_o, hash_req_o: single-cycle pulses; ks_byte_o holds its last value between pulses.
- flush_i has highest priority; next cycle:
  - state GROUND, buffer and marker cleared, ks_valid_o=0, shadow invalidated;
  - an accept in the same cycle is dropped;
  - hash_valid_i in the same cycle is discarded.
  - The outstanding flag remains set; the late hash_valid_i then arrives in GROUND, is discarded, and clears the flag.
  - New requests wait for the flag to clear.
- Reset mid-operation: immediate return to reset values; any in-flight hash is discarded.

Optional Feature:
- Macro: KS_PREFETCH_EN.
- Defined:
  - Adds a HASH_W shadow register plus shadow_valid.
  - One cycle after entering READY with the shadow empty and nothing outstanding, pulse hash_req_o; hash_valid_i in READY fills the shadow.
  - When symbol N_BYTES-1 is accepted and shadow_valid=1: the shadow moves to active, marker=0, the state stays READY and ks_ready_o stays 1 (zero bubble). The next prefetch request follows.
  - If the shadow is not yet valid: go to EXHAUSTED. If a request is outstanding, go to FETCH without re-requesting.
- Undefined: no shadow register and no prefetch; behaviour exactly as above.

Test Plan:
- Reset -> all outputs 0 and state_o=0; hold rst_n low mid-FETCH with hash_valid_i pulsed -> state stays 0 and no capture.
- BYTE_W=8, HASH_W=64; ks_req_i held high from GROUND; hash_valid_i 3 cycles after hash_req_o with 0x0807060504030201 -> ks_byte_o 01..08 on 8 consecutive cycles, remaining_o 8->1, then EXHAUSTED and exactly one further hash_req_o pulse.
- ks_req_i toggled every other cycle in READY -> one ks_valid_o per accept, 1-cycle latency, remaining_o decrements by 1 per accept.
- Flush after 3 bytes with a request outstanding -> state GROUND, remaining_o 0; late hash_valid_i (0xAA..) discarded; next fetch's first byte comes from the new word.
- flush_i and hash_valid_i in the same cycle -> data discarded, state GROUND, no ks_valid_o.
- KS_PREFETCH_EN, ks_req_i high for 16 cycles, each hash returned 2 cycles after request -> 16 contiguous ks_valid_o pulses, no bubble at the word boundary, hash_req_o pulsed 3 times.
